// File: rtl/i2s_pkg.sv
// Shared I2S definitions: controller state encoding and frame geometry.
// Imported by i2s_ctrl, i2s_clkgen and i2s_rx.
package i2s_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WARMUP = 3'd3,
        ST_RUN    = 3'd4
    } i2s_ctrl_state_t;

    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_CH_BITS    = 32;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit/word clock generator: sclk, lrck and frame_start from clk.
// Ports: clk, rst (sync, active-high), run (low = hold cleared),
//        sclk, lrck, frame_start (all registered).
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV   = 2,
    parameter int FRAME_BITS = I2S_FRAME_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic lrck,
    output logic frame_start
);

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BW = $clog2(FRAME_BITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] BIT_HALF = BW'(FRAME_BITS / 2);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nxt;

    assign bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            sclk        <= 1'b0;
            lrck        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
                // Falling edge: advance the bit and move lrck here so it
                // is stable at the next rising edge where i2s_rx samples.
                if (sclk) begin
                    bit_cnt     <= bit_nxt;
                    lrck        <= (bit_nxt >= BIT_HALF);
                    frame_start <= (bit_nxt == '0);
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_ctrl.sv
// I2S receive-path controller: codec power-up sequencing and clock run gate.
// Ports: clk, rst (sync, active-high), enable; codec_rst_n, sclk, lrck,
//        frame_start, rx_en, state_o (all registered).
module i2s_ctrl
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV       = 2,
    parameter int FRAME_BITS     = I2S_FRAME_BITS,
    parameter int RST_CYCLES     = 1024,
    parameter int SETTLE_CYCLES  = 65536,
    parameter int DISCARD_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       codec_rst_n,
    output logic       sclk,
    output logic       lrck,
    output logic       frame_start,
    output logic       rx_en,
    output logic [2:0] state_o
);

    localparam int TW = $clog2(max2(RST_CYCLES, SETTLE_CYCLES) + 1);
    localparam int FW = (DISCARD_FRAMES > 0) ? $clog2(DISCARD_FRAMES + 1) : 1;

    i2s_ctrl_state_t state;
    logic [TW-1:0]   timer;
    logic [FW-1:0]   frame_cnt;

    logic clocks_on;
    logic go_idle;
    logic cg_run;
    logic rst_done;
    logic settle_done;
    logic discard_done;

    assign clocks_on = (state == ST_WARMUP) || (state == ST_RUN);

    // RESET/SETTLE abort at once; WARMUP/RUN stop only at a frame
    // boundary so the codec never sees a partial frame.
    assign go_idle = !enable &&
                     (((state == ST_RESET) || (state == ST_SETTLE)) ||
                      (clocks_on && frame_start));

    // Combinational gate so the generator clears on the same edge the
    // FSM leaves WARMUP/RUN, instead of emitting one extra divider step.
    assign cg_run = clocks_on && !go_idle;

    assign rst_done     = (int'(timer) + 1 >= RST_CYCLES);
    assign settle_done  = (int'(timer) + 1 >= SETTLE_CYCLES);
    assign discard_done = (int'(frame_cnt) + 1 >= DISCARD_FRAMES);

    assign state_o = state;

    i2s_clkgen #(
        .SCLK_DIV   (SCLK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_clkgen (
        .clk         (clk),
        .rst         (rst),
        .run         (cg_run),
        .sclk        (sclk),
        .lrck        (lrck),
        .frame_start (frame_start)
    );

    always_ff @(posedge clk) begin
        if (rst || go_idle) begin
            state       <= ST_IDLE;
            timer       <= '0;
            frame_cnt   <= '0;
            codec_rst_n <= 1'b0;
            rx_en       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_RESET;
                        timer <= '0;
                    end
                end
                ST_RESET: begin
                    if (rst_done) begin
                        state       <= ST_SETTLE;
                        timer       <= '0;
                        codec_rst_n <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        state     <= ST_WARMUP;
                        timer     <= '0;
                        frame_cnt <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_WARMUP: begin
                    if (frame_start) begin
                        if (discard_done) begin
                            state     <= ST_RUN;
                            frame_cnt <= '0;
                            rx_en     <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    rx_en <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    timer       <= '0;
                    frame_cnt   <= '0;
                    codec_rst_n <= 1'b0;
                    rx_en       <= 1'b0;
                end
            endcase
        end
    end

endmodule
